// File: rtl/adc_stream_sequencer_if.sv
// Avalon-ST source bundle carrying packed ADC beats to the downstream FIFO.
//   src_data  : LANES*SMP_W-bit beat, lane i in bits [SMP_W*i +: SMP_W]
//   src_valid : beat qualifier
//   src_ready : sink acceptance, ready latency 0
//   src_sop   : first beat of a packet
//   src_eop   : last beat of a packet
//   src_empty : unused bytes in the last beat, 0 on all other beats
// master = sequencer (drives the beat), slave = FIFO sink (drives ready).
interface adc_stream_sequencer_if #(
  parameter int SMP_W = 64,
  parameter int LANES = 8
);
  logic [SMP_W*LANES-1:0] src_data;
  logic                   src_valid;
  logic                   src_ready;
  logic                   src_sop;
  logic                   src_eop;
  logic [5:0]             src_empty;

  modport master (
    output src_data, src_valid, src_sop, src_eop, src_empty,
    input  src_ready
  );

  modport slave (
    input  src_data, src_valid, src_sop, src_eop, src_empty,
    output src_ready
  );
endinterface

// File: rtl/adc_stream_sequencer.sv
// Packs a free-running ADC sample stream into LANES-wide Avalon-ST beats.
// A trig pulse (with cfg_enable and non-zero cfg_length) starts a packet of
// cfg_length samples; samples are packed lane by lane and handed to a
// one-beat output register. The ADC cannot be stalled: if a beat completes
// while the output register is still occupied, the beat waits in the pack
// register and every sample arriving meanwhile is dropped and flagged.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   cfg_enable       : permits a packet to start
//   cfg_length       : samples per packet (0 = triggers ignored)
//   cfg_clear        : clears overflow and pkt_count
//   trig             : single-cycle acquisition start
//   smp_data/valid   : ADC sample input, no backpressure
//   src              : Avalon-ST source (master modport)
//   busy             : high whenever a packet is in progress
//   overflow         : sticky sample-drop flag
//   pkt_count        : completed packets, wraps at 2^32
module adc_stream_sequencer #(
  parameter int SMP_W = 64,
  parameter int LANES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_enable,
  input  logic [15:0]           cfg_length,
  input  logic                  cfg_clear,
  input  logic                  trig,
  input  logic [SMP_W-1:0]      smp_data,
  input  logic                  smp_valid,
  adc_stream_sequencer_if.master src,
  output logic                  busy,
  output logic                  overflow,
  output logic [31:0]           pkt_count
);
  localparam int BEAT_W = SMP_W * LANES;
  localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, FILL, HOLD, DRAIN} state_t;

  state_t state, state_next;

  logic [15:0]       len_q;
  logic [15:0]       cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic              first_q;

  // Pack register: the beat being assembled (or parked in HOLD).
  logic [BEAT_W-1:0] pack_data_p0;

  // Output register: the beat presented on the Avalon-ST source.
  logic [BEAT_W-1:0] beat_data_p1;
  logic              vld_p1;
  logic              sop_p1;
  logic              eop_p1;
  logic [5:0]        empty_p1;

  logic              start;
  logic              take;
  logic              lane_last;
  logic              pkt_last_fill;
  logic              beat_done;
  logic              out_accept;
  logic              out_free;
  logic              hold_last;
  logic [BEAT_W-1:0] merged;

  // Lanes below 'lane' keep the packed samples, 'lane' takes the new sample,
  // lanes above are forced to zero so a short final beat needs no clearing.
  function automatic logic [BEAT_W-1:0] merge_lane(
    input logic [BEAT_W-1:0] pack,
    input logic [IDX_W-1:0]  lane,
    input logic [SMP_W-1:0]  smp
  );
    logic [BEAT_W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(lane))
        r[i*SMP_W +: SMP_W] = pack[i*SMP_W +: SMP_W];
      else if (i == int'(lane))
        r[i*SMP_W +: SMP_W] = smp;
    end
    return r;
  endfunction

  // Unused bytes of a beat whose highest written lane is 'lane'.
  function automatic logic [5:0] empty_of(input logic [IDX_W-1:0] lane);
    return 6'((LANES - 1 - int'(lane)) * (SMP_W / 8));
  endfunction

  assign start         = trig & cfg_enable & (cfg_length != 16'd0);
  assign take          = (state == FILL) & smp_valid;
  assign lane_last     = (idx_q == IDX_W'(LANES - 1));
  assign pkt_last_fill = ((cnt_q + 16'd1) == len_q);
  assign beat_done     = take & (lane_last | pkt_last_fill);
  assign out_accept    = vld_p1 & src.src_ready;
  assign out_free      = ~vld_p1 | out_accept;
  // In HOLD the counter already includes the parked beat's last sample.
  assign hold_last     = (cnt_q == len_q);
  assign merged        = merge_lane(pack_data_p0, idx_q, smp_data);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = FILL;
      FILL:  if (beat_done) begin
               if (!out_free)          state_next = HOLD;
               else if (pkt_last_fill) state_next = DRAIN;
             end
      HOLD:  if (out_free) state_next = hold_last ? DRAIN : FILL;
      DRAIN: if (out_accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q        <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      first_q      <= 1'b0;
      pack_data_p0 <= '0;
      beat_data_p1 <= '0;
      vld_p1       <= 1'b0;
      sop_p1       <= 1'b0;
      eop_p1       <= 1'b0;
      empty_p1     <= '0;
      overflow     <= 1'b0;
      pkt_count    <= '0;
    end else begin
      if (out_accept) vld_p1 <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            len_q   <= cfg_length;
            cnt_q   <= '0;
            idx_q   <= '0;
            first_q <= 1'b1;
          end
        end
        FILL: begin
          if (take) begin
            cnt_q <= cnt_q + 16'd1;
            if (!beat_done) begin
              pack_data_p0 <= merged;
              idx_q        <= idx_q + IDX_W'(1);
            end else if (out_free) begin
              // Completing sample goes straight to the output register.
              beat_data_p1 <= merged;
              vld_p1       <= 1'b1;
              sop_p1       <= first_q;
              eop_p1       <= pkt_last_fill;
              empty_p1     <= pkt_last_fill ? empty_of(idx_q) : 6'd0;
              idx_q        <= '0;
              first_q      <= 1'b0;
            end else begin
              // Park the full beat; idx stays on its last lane for empty.
              pack_data_p0 <= merged;
            end
          end
        end
        HOLD: begin
          if (smp_valid) overflow <= 1'b1;
          if (out_free) begin
            beat_data_p1 <= pack_data_p0;
            vld_p1       <= 1'b1;
            sop_p1       <= first_q;
            eop_p1       <= hold_last;
            empty_p1     <= hold_last ? empty_of(idx_q) : 6'd0;
            idx_q        <= '0;
            first_q      <= 1'b0;
          end
        end
        DRAIN: begin
          if (out_accept) pkt_count <= pkt_count + 32'd1;
        end
        default: ;
      endcase

      // Clear wins over a coincident overflow set or packet increment.
      if (cfg_clear) begin
        overflow  <= 1'b0;
        pkt_count <= '0;
      end
    end
  end

  assign src.src_data  = beat_data_p1;
  assign src.src_valid = vld_p1;
  assign src.src_sop   = sop_p1;
  assign src.src_eop   = eop_p1;
  assign src.src_empty = empty_p1;
endmodule

// File: tb/tb_adc_stream_sequencer.sv
module tb_adc_stream_sequencer;
  localparam int SMP_W  = 64;
  localparam int LANES  = 8;
  localparam int BEAT_W = SMP_W * LANES;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cfg_enable = 1'b0;
  logic [15:0]       cfg_length = '0;
  logic              cfg_clear = 1'b0;
  logic              trig = 1'b0;
  logic [SMP_W-1:0]  smp_data = '0;
  logic              smp_valid = 1'b0;
  logic              busy;
  logic              overflow;
  logic [31:0]       pkt_count;

  adc_stream_sequencer_if #(.SMP_W(SMP_W), .LANES(LANES)) src_if ();

  adc_stream_sequencer #(.SMP_W(SMP_W), .LANES(LANES)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_enable (cfg_enable),
    .cfg_length (cfg_length),
    .cfg_clear  (cfg_clear),
    .trig       (trig),
    .smp_data   (smp_data),
    .smp_valid  (smp_valid),
    .src        (src_if),
    .busy       (busy),
    .overflow   (overflow),
    .pkt_count  (pkt_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [BEAT_W-1:0] act,
                       input logic [BEAT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (packet/beat level, queues) ----------
  bit               m_active = 0;
  int               m_len = 0;
  int               m_taken = 0;
  logic [SMP_W-1:0] m_cur[$];
  bit               m_sop_next = 0;
  bit               m_held_v = 0;
  logic [BEAT_W-1:0] m_held_data = '0;
  bit               m_held_sop = 0, m_held_eop = 0;
  logic [5:0]       m_held_empty = '0;
  bit               e_valid = 0, e_sop = 0, e_eop = 0, e_overflow = 0;
  logic [BEAT_W-1:0] e_data = '0;
  logic [5:0]       e_empty = '0;
  logic [31:0]      e_pkt = '0;
  bit               acc, free, old_eop, b_sop, b_eop;
  logic [BEAT_W-1:0] b_data;
  logic [5:0]       b_empty;

  task automatic model_reset();
    m_active = 0; m_len = 0; m_taken = 0; m_cur.delete(); m_sop_next = 0;
    m_held_v = 0; e_valid = 0; e_sop = 0; e_eop = 0; e_empty = '0;
    e_data = '0; e_overflow = 0; e_pkt = '0;
  endtask

  always @(posedge clk) begin
    if (reset) model_reset();
    else begin
      acc = e_valid && src_if.src_ready;
      free = !e_valid || acc;
      old_eop = e_eop;
      if (acc) e_valid = 0;
      if (!m_active) begin
        if (trig && cfg_enable && cfg_length != 16'd0) begin
          m_active = 1; m_len = int'(cfg_length); m_taken = 0;
          m_cur.delete(); m_sop_next = 1;
        end
      end else if (m_held_v) begin
        if (smp_valid) e_overflow = 1;
        if (free) begin
          e_valid = 1; e_data = m_held_data; e_sop = m_held_sop;
          e_eop = m_held_eop; e_empty = m_held_empty; m_held_v = 0;
        end
      end else if (m_taken < m_len && smp_valid) begin
        m_cur.push_back(smp_data);
        m_taken++;
        if (m_cur.size() == LANES || m_taken == m_len) begin
          b_data = '0;
          foreach (m_cur[i]) b_data[i*SMP_W +: SMP_W] = m_cur[i];
          b_eop = (m_taken == m_len);
          b_sop = m_sop_next;
          m_sop_next = 0;
          b_empty = b_eop ? 6'((LANES - m_cur.size()) * 8) : 6'd0;
          m_cur.delete();
          if (free) begin
            e_valid = 1; e_data = b_data; e_sop = b_sop; e_eop = b_eop;
            e_empty = b_empty;
          end else begin
            m_held_v = 1; m_held_data = b_data; m_held_sop = b_sop;
            m_held_eop = b_eop; m_held_empty = b_empty;
          end
        end
      end
      if (acc && old_eop) begin e_pkt = e_pkt + 32'd1; m_active = 0; end
      if (cfg_clear) begin e_overflow = 0; e_pkt = '0; end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("model_src_valid", src_if.src_valid, e_valid);
      check("model_busy", busy, m_active);
      check("model_overflow", overflow, e_overflow);
      check("model_pkt_count", pkt_count, e_pkt);
      if (e_valid && src_if.src_valid) begin
        check("model_src_data", src_if.src_data, e_data);
        check("model_src_sop", src_if.src_sop, e_sop);
        check("model_src_eop", src_if.src_eop, e_eop);
        check("model_src_empty", src_if.src_empty, e_empty);
      end
    end
  end

  // ---------------- directed helpers -------------------------------------
  typedef struct {
    bit          en;
    logic [15:0] len;
    bit          exp_busy;
    int          exp_beats;
    logic [5:0]  exp_empty;
  } vec_t;

  vec_t tbl[7];

  int               rp_beats;
  bit               rp_first_sop, rp_last_eop;
  logic [5:0]       rp_last_empty;
  logic [BEAT_W-1:0] rp_last_data;
  logic [BEAT_W-1:0] snap;
  logic [BEAT_W-1:0] hi;
  logic [31:0]      exp_pkt = '0;
  int               k;

  function automatic logic [SMP_W-1:0] smp_of(input int id, input int s);
    return {32'(id), 32'(s) ^ 32'h5a5a_0000};
  endfunction

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic record();
    if (src_if.src_valid && src_if.src_ready) begin
      if (rp_beats == 0) rp_first_sop = src_if.src_sop;
      rp_beats++;
      rp_last_eop = src_if.src_eop;
      rp_last_empty = src_if.src_empty;
      rp_last_data = src_if.src_data;
    end
  endtask

  // Streams 'count' samples with ready high, then waits for the packet end.
  task automatic run_packet(input int id, input int start_s, input int count);
    rp_beats = 0; rp_first_sop = 0; rp_last_eop = 0; rp_last_empty = '0;
    rp_last_data = '0;
    for (int s = 0; s < count; s++) begin
      smp_valid = 1; smp_data = smp_of(id, start_s + s);
      cyc();
      record();
    end
    smp_valid = 0;
    for (int t = 0; t < 40 && busy; t++) begin
      cyc();
      record();
    end
    check("packet_end_timeout", busy, 1'b0);
  endtask

  task automatic do_trig(input bit en, input logic [15:0] len);
    cfg_enable = en; cfg_length = len; trig = 1;
    cyc();
    trig = 0; cfg_enable = 1;
  endtask

  initial begin
    tbl[0] = '{en: 1'b0, len: 16'd16, exp_busy: 1'b0, exp_beats: 0, exp_empty: 6'd0};
    tbl[1] = '{en: 1'b1, len: 16'd0,  exp_busy: 1'b0, exp_beats: 0, exp_empty: 6'd0};
    tbl[2] = '{en: 1'b1, len: 16'd16, exp_busy: 1'b1, exp_beats: 2, exp_empty: 6'd0};
    tbl[3] = '{en: 1'b1, len: 16'd11, exp_busy: 1'b1, exp_beats: 2, exp_empty: 6'd40};
    tbl[4] = '{en: 1'b1, len: 16'd1,  exp_busy: 1'b1, exp_beats: 1, exp_empty: 6'd56};
    tbl[5] = '{en: 1'b1, len: 16'd8,  exp_busy: 1'b1, exp_beats: 1, exp_empty: 6'd0};
    tbl[6] = '{en: 1'b1, len: 16'd9,  exp_busy: 1'b1, exp_beats: 2, exp_empty: 6'd56};

    src_if.src_ready = 1'b0;
    cyc(); cyc();
    check("reset_src_valid", src_if.src_valid, 1'b0);
    check("reset_src_data", src_if.src_data, '0);
    check("reset_sop_eop_empty", {src_if.src_sop, src_if.src_eop, src_if.src_empty}, '0);
    check("reset_busy", busy, 1'b0);
    check("reset_overflow", overflow, 1'b0);
    check("reset_pkt_count", pkt_count, '0);
    reset = 0;
    cyc();

    // Table-driven trigger qualification and packet shapes.
    src_if.src_ready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      do_trig(tbl[v].en, tbl[v].len);
      check($sformatf("tbl%0d_busy", v), busy, tbl[v].exp_busy);
      if (tbl[v].exp_busy) begin
        run_packet(v, 0, int'(tbl[v].len));
        exp_pkt = exp_pkt + 32'd1;
        k = ((int'(tbl[v].len) - 1) % LANES) + 1;
        check($sformatf("tbl%0d_beats", v), 32'(rp_beats), 32'(tbl[v].exp_beats));
        check($sformatf("tbl%0d_sop", v), rp_first_sop, 1'b1);
        check($sformatf("tbl%0d_eop", v), rp_last_eop, 1'b1);
        check($sformatf("tbl%0d_empty", v), rp_last_empty, tbl[v].exp_empty);
        check($sformatf("tbl%0d_last_lane", v), rp_last_data[(k-1)*SMP_W +: SMP_W],
              smp_of(v, int'(tbl[v].len) - 1));
        hi = rp_last_data >> (k * SMP_W);
        check($sformatf("tbl%0d_zero_lanes", v), hi, '0);
      end
      check($sformatf("tbl%0d_pkt_count", v), pkt_count, exp_pkt);
    end

    // Trigger during FILL is ignored and the latched length is kept.
    do_trig(1'b1, 16'd16);
    for (int s = 0; s < 3; s++) begin
      smp_valid = 1; smp_data = smp_of(20, s); cyc();
    end
    cfg_length = 16'd5; trig = 1; smp_data = smp_of(20, 3);
    cyc();
    trig = 0; cfg_length = 16'd16;
    check("fill_trig_busy", busy, 1'b1);
    run_packet(20, 4, 12);
    exp_pkt = exp_pkt + 32'd1;
    check("fill_trig_beats", 32'(rp_beats), 32'd2);
    check("fill_trig_eop_empty", {rp_last_eop, rp_last_empty}, {1'b1, 6'd0});
    check("fill_trig_pkt_count", pkt_count, exp_pkt);

    // Stall: ready low, HOLD at sample 16, later samples dropped.
    src_if.src_ready = 1'b0;
    do_trig(1'b1, 16'd24);
    snap = '0;
    for (int s = 0; s < 24; s++) begin
      smp_valid = 1; smp_data = smp_of(30, s);
      cyc();
      if (s == 7) snap = src_if.src_data;
      if (s == 15) check("stall_no_overflow_yet", overflow, 1'b0);
      if (s == 16) check("stall_overflow_set", overflow, 1'b1);
    end
    smp_valid = 0;
    check("stall_data_stable", src_if.src_data, snap);
    check("stall_first_lane", snap[SMP_W-1:0], smp_of(30, 0));
    check("stall_valid_sop", {src_if.src_valid, src_if.src_sop}, 2'b11);
    src_if.src_ready = 1'b1;
    cyc();
    check("stall_beat2_valid", {src_if.src_valid, src_if.src_sop}, 2'b10);
    check("stall_beat2_lane0", src_if.src_data[SMP_W-1:0], smp_of(30, 8));
    cyc();
    check("stall_refill_busy", {src_if.src_valid, busy}, 2'b01);
    run_packet(30, 16, 8);
    exp_pkt = exp_pkt + 32'd1;
    check("stall_tail_beat", {32'(rp_beats), rp_first_sop, rp_last_eop},
          {32'd1, 1'b0, 1'b1});
    check("stall_pkt_count", pkt_count, exp_pkt);

    // Reset mid-packet, then a clean packet.
    do_trig(1'b1, 16'd16);
    for (int s = 0; s < 5; s++) begin
      smp_valid = 1; smp_data = smp_of(40, s); cyc();
    end
    smp_valid = 0;
    reset = 1;
    #1;
    check("midrst_outputs", {src_if.src_valid, src_if.src_eop, busy, overflow}, '0);
    check("midrst_pkt_count", pkt_count, '0);
    exp_pkt = '0;
    cyc();
    reset = 0;
    for (int t = 0; t < 3; t++) begin
      cyc();
      check("postrst_quiet", {src_if.src_valid, busy}, 2'b00);
    end
    do_trig(1'b1, 16'd16);
    run_packet(41, 0, 16);
    exp_pkt = exp_pkt + 32'd1;
    check("postrst_packet", {32'(rp_beats), rp_first_sop, rp_last_eop},
          {32'd2, 1'b1, 1'b1});
    check("postrst_pkt_count", pkt_count, exp_pkt);

    // cfg_clear coincident with final-beat acceptance.
    src_if.src_ready = 1'b0;
    do_trig(1'b1, 16'd16);
    for (int s = 0; s < 17; s++) begin
      smp_valid = 1; smp_data = smp_of(50, s); cyc();
    end
    smp_valid = 0;
    check("clr_overflow_before", overflow, 1'b1);
    src_if.src_ready = 1'b1;
    cyc();
    check("clr_last_beat_up", {src_if.src_valid, src_if.src_eop}, 2'b11);
    cfg_clear = 1;
    cyc();
    cfg_clear = 0;
    check("clr_pkt_count", pkt_count, '0);
    check("clr_overflow", overflow, 1'b0);
    check("clr_idle", busy, 1'b0);

    // Randomized traffic checked by the model.
    for (int c = 0; c < 4000; c++) begin
      trig = ($urandom_range(0, 9) == 0);
      cfg_enable = ($urandom_range(0, 9) != 0);
      cfg_length = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
      smp_valid = ($urandom_range(0, 9) < 7);
      smp_data = {$urandom, $urandom};
      src_if.src_ready = ($urandom_range(0, 9) < 6);
      cfg_clear = ($urandom_range(0, 49) == 0);
      reset = ($urandom_range(0, 299) == 0);
      cyc();
      reset = 0;
    end
    trig = 0; smp_valid = 0; cfg_clear = 0; src_if.src_ready = 1'b1;
    for (int t = 0; t < 10; t++) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
